serial_word_tx: RTL
===================

# serial_word_tx

Parallel-to-serial transmitter that unloads a DATA_W-bit word onto a single asynchronous serial line. The frame is a start bit, the data bits LSB-first, an optional even-parity bit and a stop bit. It is the sending end of the lab's register/capture datapath: upstream logic presents a word with a load strobe, and the block serializes it for an external serial receiver. All state advances only on clock-enabled cycles, so the bit rate is set by `BAUD_DIV` together with the `en` strobe.

## Interface
Parameters:
- `DATA_W`, default 5: data bits per frame, 1..16.
- `BAUD_DIV`, default 4: enabled clock cycles per serial bit, ≥1.
- `PARITY_EN`, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: clock enable; when low, all state, counters and `tx` hold.
- `D` in DATA_W: word to transmit, sampled on an accepted load.
- `load` in 1: load request; accepted on an edge where `load && ready && en`.
- `ready` out 1: high only in IDLE; the block can accept a word.
- `busy` out 1: equals `!ready`; a frame is in progress.
- `tx` out 1: registered serial line, idle high.
- `done` out 1: one-clk pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1, `ready`=1.
  - On an accepted load: shift register ← `D`, parity register ← XOR of `D`, bit counter ← 0, baud counter ← 0, go to START.
- **START**: `tx`=0 for `BAUD_DIV` enabled cycles, then go to DATA.
- **DATA**
  - `tx` = shift register bit 0; shift right once per completed bit period.
  - After `DATA_W` bits: go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
- **PARITY**: `tx` = XOR of the loaded word (even parity: the total count of ones in data plus parity is even), held for `BAUD_DIV` cycles.
- **STOP**: `tx`=1 for `BAUD_DIV` cycles, then go to IDLE and set `done`=1.
- Baud counter rules:
  - Counts 0..`BAUD_DIV`-1 on enabled cycles only.
  - Wraps to 0 at the end of each bit period.
  - With `BAUD_DIV`=1, every enabled cycle is one bit.
- Bit counter width is `$clog2(DATA_W+1)`; no overflow is possible.
- Loads while busy or while `en`=0 are ignored. The shift register and `D` sampling are unaffected.
- `D` may change freely after acceptance; the frame uses the latched copy.
- `done` is set only on an enabled edge and cleared unconditionally on the next clk edge.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0, `done`=0, state=IDLE, counters=0. These apply immediately on `rst` (asynchronous), including mid-frame: the frame is aborted with no `done`.
- Latency from the accepting edge E0 to the start bit is 0 cycles after E0: `tx` falls right after E0.
- Frame length F = (2 + `DATA_W` + `PARITY_EN`) × `BAUD_DIV` enabled cycles.
- The stop bit ends at edge E_F. Between E_F and E_F+1:
  - `done`=1, `ready`=1, `tx`=1.
  - A load in this cycle is accepted at E_F+1, so the minimum idle time between frames is `BAUD_DIV`+1 cycles of high line.
- With `en` toggling, each disabled cycle stretches the current bit by one clk; the frame shape is unchanged.
- If `load` and `rst` occur together, `rst` wins.

## Test plan
- **Reset**: assert `rst` mid-DATA bit 2 → `tx`=1, `ready`=1, `busy`=0 immediately; `done` never pulses; a new load is accepted after release.
- **Basic frame** (defaults), load `D`=5'b10110 at E0 with `en`=1 → `tx` per 4-cycle bit: 0, 0,1,1,0,1, parity 1, stop 1. `done` is high exactly between E32 and E33; `busy` is high from E0 to E32.
- **Back-to-back**: load 5'b00000 then 5'b11111, the second held on `load` → second start bit begins at E33. Second frame data is all 1s and parity is 1; first frame parity is 0.
- **Busy load rejection**: pulse `load` with `D`=5'b01010 at E10 of a frame carrying 5'b10110 → transmitted bits are unchanged and no extra frame follows.
- **Enable gating**: `en` low for 3 cycles inside the parity bit → that bit lasts 7 clks, total frame 35 clks, `done` occurs once. A load with `en`=0 while idle is ignored.
- **PARITY_EN=0, BAUD_DIV=1, DATA_W=8**: load 8'hA5 → frame 0,1,0,1,0,0,1,0,1,1 over 10 cycles with no parity bit; `done` follows at E10.

Source files
------------

// File: rtl/serial_word_tx.sv
// serial_word_tx: parallel-to-serial frame transmitter.
// Frame = start(0), DATA_W data bits LSB-first, optional even parity, stop(1).
// Every state change, counter step and tx update is qualified by en, so the
// bit period is BAUD_DIV enabled cycles.
module serial_word_tx #(
  parameter int DATA_W    = 5,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] D,
  input  logic              load,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par, par_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [BW-1:0]     baud_cnt, baud_cnt_n;
  logic              tx_n, done_n;
  logic              bit_end;

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  // Last enabled cycle of the current bit period.
  assign bit_end = en && (baud_cnt == BAUD_LAST);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    par_n      = par;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    done_n     = 1'b0;
    tx_n       = 1'b1;

    case (state)
      IDLE: begin
        if (load && en) begin
          state_n    = START;
          shreg_n    = D;
          par_n      = ^D;
          bit_cnt_n  = '0;
          baud_cnt_n = '0;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Baud counter runs only while a frame is in progress.
    if (state != IDLE && en) begin
      if (bit_end) baud_cnt_n = '0;
      else         baud_cnt_n = baud_cnt + BW'(1);
    end

    // tx is registered from the next state so the start bit appears right
    // after the accepting edge.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      par      <= par_n;
      bit_cnt  <= bit_cnt_n;
      baud_cnt <= baud_cnt_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end

endmodule
